// File: rtl/ifq_line_fetcher.sv
// Write-side producer for the instruction fetch queue: fetches 16-byte lines one at a time
// and pushes each returned line into the queue, restarting at the target on a redirect.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | not fetching; waits for i_start (or a flush)
// REQ      | request valid on o_req_addr until the memory accepts it
// WAIT     | request accepted; waiting for its response
// WRITE    | line held in line_buf; written to the queue when not full
// DRAIN    | a redirected request is still outstanding; drop its response
module ifq_line_fetcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_boot_pc,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_req_valid,
    output logic [ADDR_WIDTH-1:0] o_req_addr,
    input  logic                  i_req_ready,
    input  logic                  i_resp_valid,
    input  logic [LINE_WIDTH-1:0] i_resp_data,
    output logic [LINE_WIDTH-1:0] o_fifo_data,
    output logic                  o_fifo_wen,
    input  logic                  i_fifo_full,
    output logic [1:0]            o_line_offset,
    output logic                  o_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(15);
    localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(16);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [LINE_WIDTH-1:0] line_buf_q, line_buf_d;
    logic [1:0]            offset_q, offset_d;
    logic                  first_line_q, first_line_d;
    logic                  fifo_wen;

    // Flush must also suppress the write: the queue is being flushed that same cycle.
    assign fifo_wen = (state_q == ST_WRITE) && !i_fifo_full && !i_flush;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        line_buf_d   = line_buf_q;
        offset_d     = offset_q;
        first_line_d = first_line_q;
        if (i_flush) begin
            fetch_pc_d   = i_redirect_pc & LINE_MASK;
            offset_d     = i_redirect_pc[3:2];
            first_line_d = 1'b1;
            case (state_q)
                ST_REQ:   state_d = i_req_ready ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_d = i_resp_valid ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        fetch_pc_d   = i_boot_pc & LINE_MASK;
                        offset_d     = i_boot_pc[3:2];
                        first_line_d = 1'b1;
                        state_d      = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_req_ready) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_resp_valid) begin
                        line_buf_d = i_resp_data;
                        state_d    = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (fifo_wen) begin
                        fetch_pc_d   = fetch_pc_q + LINE_BYTES;
                        first_line_d = 1'b0;
                        state_d      = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (i_resp_valid) state_d = ST_REQ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= '0;
            line_buf_q   <= '0;
            offset_q     <= '0;
            first_line_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            line_buf_q   <= line_buf_d;
            offset_q     <= offset_d;
            first_line_q <= first_line_d;
        end
    end

    assign o_req_valid   = (state_q == ST_REQ);
    assign o_req_addr    = fetch_pc_q;
    assign o_fifo_data   = line_buf_q;
    assign o_fifo_wen    = fifo_wen;
    assign o_line_offset = (state_q == ST_WRITE && first_line_q) ? offset_q : 2'd0;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: doc/ifq_line_fetcher.md
Name: ifq_line_fetcher

Overview:
- Producer (write side) of the instruction fetch queue.
- Issues line-aligned 128-bit fetch requests to instruction memory/cache, one outstanding at a time.
- Pushes each returned line into the queue as a single write; the queue's reader consumes it as four 32-bit words.
- On branch/flush redirect, drops in-flight work, discards stale responses and restarts at the redirect target.

Parameters:
ADDR_WIDTH, 32, byte address width of PC and request address
LINE_WIDTH, 128, line width; four 32-bit words, fixed line size 16 bytes

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_start  in  1  one-cycle pulse: begin fetching at i_boot_pc
i_boot_pc  in  ADDR_WIDTH  initial fetch PC
i_flush  in  1  redirect; same signal that flushes the queue
i_redirect_pc  in  ADDR_WIDTH  new fetch PC, sampled when i_flush=1
o_req_valid  out  1  fetch request valid
o_req_addr  out  ADDR_WIDTH  line address, bits [3:0]=0
i_req_ready  in  1  memory accepts request when o_req_valid & i_req_ready
i_resp_valid  in  1  one-cycle response strobe for the accepted request
i_resp_data  in  LINE_WIDTH  returned line, word0 in [31:0]
o_fifo_data  out  LINE_WIDTH  line to queue data_in
o_fifo_wen  out  1  queue w_en
i_fifo_full  in  1  queue full
o_line_offset  out  2  word offset of first valid word in current write (PC[3:2]); 0 except first line after start/redirect
o_busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low on i_rst_n; clock is i_clk.
- Reset values:
  - state=IDLE; fetch_pc=0; line_buf=0; first_line=0.
  - Outputs: o_req_valid=0, o_req_addr=0, o_fifo_wen=0, o_fifo_data=0, o_line_offset=0, o_busy=0.
- Reset mid-operation abandons everything; a late i_resp_valid seen in IDLE is ignored.
- fetch_pc: register, always line-aligned (low 4 bits forced 0). o_req_addr=fetch_pc.
- offset_reg: holds PC[3:2] of the start/redirect PC. first_line is set on start/redirect and cleared after the first queue write.
- States:
  - IDLE: no outputs asserted. On i_start (or i_flush): load fetch_pc from the aligned PC, set first_line, go to REQ.
  - REQ: o_req_valid=1. On i_req_ready, go to WAIT.
  - WAIT: on i_resp_valid, latch i_resp_data into line_buf and go to WRITE.
  - WRITE:
    - o_fifo_data=line_buf; o_fifo_wen = !i_fifo_full & !i_flush; o_line_offset = first_line ? offset_reg : 0.
    - On a write: fetch_pc += 16 (wraps modulo 2^ADDR_WIDTH), clear first_line, go to REQ.
    - While i_fifo_full: hold state and line_buf, o_fifo_wen=0.
  - DRAIN: o_req_valid=0. Waits for the response to the stale request. On i_resp_valid, discard it (no write) and go to REQ.
- Minimum loop REQ->WAIT->WRITE->REQ is 3 cycles per line when i_req_ready=1 and the response arrives the cycle after acceptance.
- Flush (highest priority, every state). fetch_pc<=aligned i_redirect_pc, offset_reg<=i_redirect_pc[3:2], first_line<=1, o_fifo_wen forced 0 that cycle. Next state:
  - IDLE, or REQ with !i_req_ready, or WRITE: go to REQ; a pending line_buf is dropped.
  - REQ with i_req_ready the same cycle: request was accepted, go to DRAIN.
  - WAIT with no i_resp_valid: go to DRAIN.
  - WAIT with i_resp_valid the same cycle: discard response, go to REQ.
  - DRAIN: stay in DRAIN, update redirect PC (latest flush wins).
- i_start is ignored outside IDLE.
- Invariants:
  - Never more than one accepted-but-unanswered request.
  - o_fifo_wen is never asserted while i_fifo_full=1.
  - o_req_valid, once high, holds with a stable address until accepted or flushed.

Test Plan:
- Reset, i_start with i_boot_pc=0x1000, ready=1, response 1 cycle after accept, fifo not full -> requests 0x1000, 0x1010, 0x1020 in order; one o_fifo_wen per line carrying its i_resp_data; first write o_line_offset=0; 3 cycles per line.
- i_boot_pc=0x200C -> first o_req_addr=0x2000; first write o_line_offset=3; second line 0x2010 has offset 0.
- i_fifo_full=1 for 5 cycles while in WRITE -> o_fifo_wen=0, no new request, line_buf unchanged; write occurs the cycle full drops, then request 0x...+16.
- Flush with i_redirect_pc=0x4008 while in WAIT, response arrives 4 cycles later -> response not written, then o_req_addr=0x4000; its write has o_line_offset=2.
- Flush coincident with i_resp_valid, and flush coincident with REQ accept -> first: no write, next request at redirect; second: DRAIN, one stale response dropped, then redirect request.
- fetch_pc=0xFFFFFFF0 (ADDR_WIDTH=32) -> next request 0x00000000. Assert i_rst_n=0 mid-WAIT, then send a late response -> all outputs 0, no write.
